// File: rtl/ip_sequencer.sv
`timescale 1ns/1ps
// ip_sequencer
//   Paces CPU instruction execution and owns the instruction pointer. A pacing
//   counter produces a slow execute tick (every CNT_MAX+1 cycles), or a tick
//   every cycle while Turbo is on. On each tick the instruction presented on
//   Instr is executed: IP advances by one or jumps to Instr[7:0]. A WAIT
//   instruction stalls until a Sample press has been seen.
//
//   Optional build macro IP_SEQ_SINGLE_STEP_EN adds StepMode/StepBtn. While
//   StepMode is on, the only tick source is a StepBtn rising edge.
//
// Ports
//   Clock    in   system clock, all state on posedge
//   Reset    in   synchronous, active-high
//   Turbo    in   async switch, high = tick every cycle
//   Sample   in   async push-button, rising edge releases a wait
//   Instr    in   35-bit instruction at IP ([34:33] jump mode, [32] WAIT, [7:0] target)
//   Cond     in   condition flag for conditional jumps
//   IP       out  instruction pointer / ROM address
//   Go       out  one-cycle pulse, previous IP executed at this edge
//   Waiting  out  high while stalled on a WAIT instruction
//   StepMode in   (IP_SEQ_SINGLE_STEP_EN only) single-step enable
//   StepBtn  in   (IP_SEQ_SINGLE_STEP_EN only) single-step button
module ip_sequencer #(
    parameter int unsigned CNT_MAX = 12500000,
    parameter int unsigned CNT_W   = 24
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Turbo,
    input  logic        Sample,
    input  logic [34:0] Instr,
    input  logic        Cond,
    output logic [7:0]  IP,
    output logic        Go,
    output logic        Waiting
`ifdef IP_SEQ_SINGLE_STEP_EN
    ,
    input  logic        StepMode,
    input  logic        StepBtn
`endif
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t           state;
    logic             turbo_q1, turbo_q2;
    logic             sample_q1, sample_q2;
    logic             pend;
    logic [CNT_W-1:0] cnt;

    logic             slow_tick;
    logic             tick;
    logic             sample_edge;
    logic             sample_ok;
    logic             wait_flag;
    logic             taken;
    logic             execute;
    logic             unused_instr_bits;

    assign unused_instr_bits = ^Instr[31:8];

    assign slow_tick   = (cnt == CNT_W'(CNT_MAX));
    assign sample_edge = sample_q1 & ~sample_q2;
    // A press arriving in the same cycle as the tick already counts.
    assign sample_ok   = pend | sample_edge;
    assign wait_flag   = Instr[32];

`ifdef IP_SEQ_SINGLE_STEP_EN
    logic step_mode_q1, step_mode_q2;
    logic step_btn_q1, step_btn_q2;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            step_mode_q1 <= 1'b0;
            step_mode_q2 <= 1'b0;
            step_btn_q1  <= 1'b0;
            step_btn_q2  <= 1'b0;
        end else begin
            step_mode_q1 <= StepMode;
            step_mode_q2 <= step_mode_q1;
            step_btn_q1  <= StepBtn;
            step_btn_q2  <= step_btn_q1;
        end
    end

    assign tick = step_mode_q2 ? (step_btn_q1 & ~step_btn_q2)
                               : (slow_tick | turbo_q2);
`else
    assign tick = slow_tick | turbo_q2;
`endif

    always_comb begin
        unique case (Instr[34:33])
            2'b00:   taken = 1'b0;
            2'b01:   taken = 1'b1;
            2'b10:   taken = Cond;
            default: taken = ~Cond;
        endcase
    end

    always_comb begin
        execute = 1'b0;
        if (tick) begin
            unique case (state)
                ST_RUN:  execute = ~(wait_flag & ~sample_ok);
                ST_WAIT: execute = sample_ok;
                default: execute = 1'b0;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= ST_RUN;
            IP        <= '0;
            Go        <= 1'b0;
            Waiting   <= 1'b0;
            cnt       <= '0;
            pend      <= 1'b0;
            turbo_q1  <= 1'b0;
            turbo_q2  <= 1'b0;
            sample_q1 <= 1'b0;
            sample_q2 <= 1'b0;
        end else begin
            turbo_q1  <= Turbo;
            turbo_q2  <= turbo_q1;
            sample_q1 <= Sample;
            sample_q2 <= sample_q1;

            cnt <= slow_tick ? '0 : cnt + CNT_W'(1);

            // An executed WAIT consumes the press, including a same-cycle one.
            pend <= (execute & wait_flag) ? 1'b0 : (pend | sample_edge);

            Go <= execute;
            if (execute)
                IP <= taken ? Instr[7:0] : IP + 8'd1;

            unique case (state)
                ST_RUN: begin
                    if (tick && !execute) begin
                        state   <= ST_WAIT;
                        Waiting <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (execute) begin
                        state   <= ST_RUN;
                        Waiting <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_RUN;
                    Waiting <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ip_sequencer.sv
`timescale 1ns/1ps
// Testbench for ip_sequencer with CNT_MAX=3 (tick every 4 cycles).
// A bench-side ROM/Cond table feeds Instr and Cond from IP. Stimulus pushes
// the expected IP after every execute (plus the expected spacing between Go
// pulses, 0 = don't care); a monitor pops one entry per Go pulse.
module tb_ip_sequencer;

    logic        Clock;
    logic        Reset;
    logic        Turbo;
    logic        Sample;
    logic [34:0] Instr;
    logic        Cond;
    logic [7:0]  IP;
    logic        Go;
    logic        Waiting;

    logic [34:0] rom      [256];
    logic        cond_mem [256];

    assign Instr = rom[IP];
    assign Cond  = cond_mem[IP];

    ip_sequencer #(
        .CNT_MAX(3),
        .CNT_W  (4)
    ) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .Turbo   (Turbo),
        .Sample  (Sample),
        .Instr   (Instr),
        .Cond    (Cond),
        .IP      (IP),
        .Go      (Go),
        .Waiting (Waiting)
`ifdef IP_SEQ_SINGLE_STEP_EN
        ,
        .StepMode(1'b0),
        .StepBtn (1'b0)
`endif
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic [7:0] ip;
        int         gap;
    } exp_t;

    exp_t q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    function automatic logic [34:0] mk(input logic [1:0] mode, input logic w, input logic [7:0] tgt);
        return {mode, w, 24'd0, tgt};
    endfunction

    task automatic push(input logic [7:0] ip, input int gap);
        exp_t e;
        e.ip  = ip;
        e.gap = gap;
        q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) begin
            rom[i]      = '0;
            cond_mem[i] = 1'b0;
        end
    endtask

    task automatic start_phase();
        Reset = 1'b1;
        clear_rom();
        repeat (2) @(negedge Clock);
    endtask

    task automatic wait_drain(input int limit);
        for (int i = 0; i < limit; i++) begin
            if (q.size() == 0) return;
            @(negedge Clock);
        end
        if (q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: %0d executes still outstanding, expected 0", q.size());
            q.delete();
        end
    endtask

    task automatic wait_waiting(input int limit);
        for (int i = 0; i < limit; i++) begin
            if (Waiting === 1'b1) return;
            @(negedge Clock);
        end
        vectors++;
        miscompares++;
        $display("FAIL waiting_timeout: Waiting=%b, expected 1", Waiting);
    endtask

    task automatic wait_ip(input logic [7:0] target, input int limit);
        for (int i = 0; i < limit; i++) begin
            if (IP === target) return;
            @(negedge Clock);
        end
        vectors++;
        miscompares++;
        $display("FAIL ip_timeout: IP=%h, expected %h", IP, target);
    endtask

    // Monitor: one scoreboard pop per Go pulse.
    initial begin
        int   cyc;
        int   last;
        exp_t e;
        cyc  = 0;
        last = 0;
        forever begin
            @(posedge Clock);
            #1;
            cyc++;
            if (Go === 1'b1) begin
                vectors++;
                if (q.size() == 0) begin
                    miscompares++;
                    $display("FAIL go_unexpected: Go=1 with IP=%h, expected no execute", IP);
                end else begin
                    e = q.pop_front();
                    if (IP !== e.ip || Waiting !== 1'b0 ||
                        (e.gap != 0 && (cyc - last) != e.gap)) begin
                        miscompares++;
                        $display("FAIL go_ip: IP=%h Waiting=%b gap=%0d, expected IP=%h Waiting=0 gap=%0d",
                                 IP, Waiting, cyc - last, e.ip, e.gap);
                    end
                end
                last = cyc;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset  = 1'b1;
        Turbo  = 1'b0;
        Sample = 1'b0;
        clear_rom();
        repeat (3) @(negedge Clock);
        chk("reset_ip", {1'b0, IP}, 9'h000);
        chk("reset_go", {8'h00, Go}, 9'h000);
        chk("reset_waiting", {8'h00, Waiting}, 9'h000);

        // Straight-line program: 256 increments with wrap, Go every 4 cycles.
        for (int i = 0; i < 256; i++)
            push(8'((i + 1) % 256), (i == 0) ? 0 : 4);
        Reset = 1'b0;
        wait_drain(1100);

        // Jump modes.
        start_phase();
        rom[8'h05]      = mk(2'b01, 1'b0, 8'h40);
        rom[8'h40]      = mk(2'b10, 1'b0, 8'h80);
        rom[8'h41]      = mk(2'b11, 1'b0, 8'h60);
        rom[8'h60]      = mk(2'b10, 1'b0, 8'h70);
        cond_mem[8'h60] = 1'b1;
        rom[8'h70]      = mk(2'b11, 1'b0, 8'h90);
        cond_mem[8'h70] = 1'b1;
        rom[8'h71]      = mk(2'b01, 1'b0, 8'h71);
        push(8'h01, 0);
        push(8'h02, 4);
        push(8'h03, 4);
        push(8'h04, 4);
        push(8'h05, 4);
        push(8'h40, 4);
        push(8'h41, 4);
        push(8'h60, 4);
        push(8'h70, 4);
        push(8'h71, 4);
        push(8'h71, 4);
        push(8'h71, 4);
        Reset = 1'b0;
        wait_drain(80);

        // WAIT stall, release by Sample, pend consumed.
        start_phase();
        rom[8'h03] = mk(2'b00, 1'b1, 8'h00);
        rom[8'h05] = mk(2'b00, 1'b1, 8'h00);
        push(8'h01, 0);
        push(8'h02, 4);
        push(8'h03, 4);
        Reset = 1'b0;
        wait_drain(40);
        wait_waiting(20);
        chk("wait_enter_ip", {1'b0, IP}, 9'h003);
        repeat (20) @(negedge Clock);
        chk("wait_hold_ip", {1'b0, IP}, 9'h003);
        chk("wait_hold_flag", {8'h00, Waiting}, 9'h001);
        push(8'h04, 0);
        push(8'h05, 4);
        Sample = 1'b1;
        repeat (4) @(negedge Clock);
        Sample = 1'b0;
        wait_drain(40);
        wait_waiting(20);
        chk("wait_pend_cleared_ip", {1'b0, IP}, 9'h005);

        // Early press is remembered across a non-wait instruction.
        start_phase();
        rom[8'h03] = mk(2'b00, 1'b1, 8'h00);
        rom[8'h04] = mk(2'b00, 1'b1, 8'h00);
        push(8'h01, 0);
        push(8'h02, 4);
        push(8'h03, 4);
        push(8'h04, 4);
        Reset = 1'b0;
        wait_ip(8'h02, 40);
        Sample = 1'b1;
        repeat (4) @(negedge Clock);
        Sample = 1'b0;
        wait_drain(40);
        wait_waiting(20);
        chk("pend_second_wait_ip", {1'b0, IP}, 9'h004);

        // Turbo: after 2-cycle sync delay one execute per cycle, then back
        // to the free-running slow cadence.
        start_phase();
        push(8'h01, 0);
        push(8'h02, 4);
        Reset = 1'b0;
        wait_drain(40);
        push(8'h03, 3);
        for (int i = 4; i <= 12; i++)
            push(8'(i), 1);
        push(8'h0D, 4);
        push(8'h0E, 4);
        Turbo = 1'b1;
        repeat (10) @(negedge Clock);
        Turbo = 1'b0;
        wait_drain(40);

        // Reset while stalled at 8'h20 with a press already latched.
        start_phase();
        rom[8'h20] = mk(2'b00, 1'b1, 8'h00);
        for (int i = 1; i <= 32; i++)
            push(8'(i), (i == 1) ? 0 : 4);
        Reset = 1'b0;
        wait_drain(200);
        wait_waiting(20);
        chk("stall_20_ip", {1'b0, IP}, 9'h020);
        Sample = 1'b1;
        @(negedge Clock);
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        Sample = 1'b0;
        chk("midwait_reset_ip", {1'b0, IP}, 9'h000);
        chk("midwait_reset_waiting", {8'h00, Waiting}, 9'h000);
        chk("midwait_reset_go", {8'h00, Go}, 9'h000);
        clear_rom();
        rom[8'h01] = mk(2'b00, 1'b1, 8'h00);
        repeat (3) @(negedge Clock);
        push(8'h01, 0);
        Reset = 1'b0;
        wait_drain(20);
        wait_waiting(20);
        chk("no_stale_pend_ip", {1'b0, IP}, 9'h001);
        repeat (12) @(negedge Clock);
        chk("no_stale_pend_hold_ip", {1'b0, IP}, 9'h001);
        chk("no_stale_pend_waiting", {8'h00, Waiting}, 9'h001);

        chk("scoreboard_empty", 9'(q.size()), 9'h000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ip_sequencer.md
Name: ip_sequencer

Overview:
- Paces CPU instruction execution and owns the instruction pointer.
- Produces the execute tick (slow 250 ms cadence or turbo), then advances IP by increment or jump.
- Stalls on wait-for-input instructions until a Sample press arrives.
- Sits directly upstream of program memory: IP drives the ROM address; the fetched 35-bit instruction word feeds back for jump/wait control.

Parameters:
- CNT_MAX, 12500000, slow-mode tick period minus one in Clock cycles (250 ms at 50 MHz).
- CNT_W, 24, pacing counter width; must hold CNT_MAX.

Ports:
- Clock  input  1  system clock; all state on posedge.
- Reset  input  1  synchronous, active-high.
- Turbo  input  1  asynchronous switch; high = tick every cycle.
- Sample  input  1  asynchronous push-button; a rising edge releases a wait.
- Instr  input  35  current instruction from program memory (combinational from IP).
- Cond  input  1  condition flag from execute stage, valid while Instr is valid.
- IP  output  8  instruction pointer / ROM address.
- Go  output  1  one-cycle pulse; the instruction at the previous IP executed this edge.
- Waiting  output  1  high while stalled in WAIT.

Behaviour:
- Instruction fields used here:
  - Instr[34:33] jump mode: 00 none, 01 always, 10 if Cond=1, 11 if Cond=0.
  - Instr[32] WAIT flag.
  - Instr[7:0] jump target.
  - All other bits are ignored.
- Synchronisers: Turbo and Sample each pass through a 2-flop synchroniser.
  - Sample rising edge (sync q1=1, q2=0) sets a sticky `pend` flag.
  - `pend` clears only when consumed by an executed WAIT instruction.
- Pacing counter cnt (CNT_W bits):
  - Resets to 0 and increments every cycle.
  - When cnt==CNT_MAX, the next value is 0.
  - slow_tick = (cnt==CNT_MAX).
  - tick = slow_tick OR synced Turbo.
  - Turbo does not reset cnt.
- sample_ok = pend OR Sample edge in the current cycle (a same-cycle edge counts).
- FSM states:
  - RUN (reset state):
    - On tick, if WAIT=1 and !sample_ok: go to WAIT; IP holds; Go=0.
    - Otherwise: execute.
  - WAIT:
    - On tick with sample_ok: execute and return to RUN.
    - Otherwise: hold.
- Execute, in a single edge:
  - IP <= taken ? Instr[7:0] : IP+1, where taken follows the jump mode using the current Cond.
  - Go <= 1; Go is 0 on every other cycle.
  - If WAIT=1, clear `pend`.
- IP increment wraps 8'hFF -> 8'h00. A jump to the current IP is legal (self-loop).
- Waiting = (state==WAIT), registered.
- Reset (any cycle, including mid-WAIT) forces:
  - IP=0, Go=0, Waiting=0, state=RUN, cnt=0, pend=0, synchroniser flops=0.
  - Reset overrides a coincident tick.
- Latency:
  - Slow mode, from reset release: first tick in cycle CNT_MAX+1.
  - Go/IP change is visible one edge after the tick cycle.
  - Turbo: one execute per cycle, starting 2 cycles after Turbo rises (synchroniser delay).

Optional Feature:
- Macro IP_SEQ_SINGLE_STEP_EN.
- When defined, adds ports StepMode (input, 1) and StepBtn (input, 1), both 2-flop synchronised.
  - While synced StepMode=1, tick = StepBtn rising edge only; slow_tick and Turbo are ignored.
  - cnt keeps running.
- When undefined, these ports do not exist and tick is as above.

Test Plan:
- CNT_MAX=3, Instr all zero, Reset held then released -> Go pulses every 4 cycles; IP reads 1,2,3...; after 256 executes IP wraps from 8'hFF to 8'h00.
- CNT_MAX=3, Instr[34:33]=01, Instr[7:0]=8'h40 at IP=5 -> next IP=8'h40 with Go=1; with mode 10 and Cond=0 -> IP=6; with mode 11 and Cond=0 -> IP=8'h40.
- Instr[32]=1 at IP=3, no Sample -> at tick Waiting=1 and IP stays 3 across 5 ticks; Sample pulse high 4 cycles -> next tick gives IP=4, Go=1, Waiting=0, pend=0.
- Sample pressed while IP=2 (non-wait), then IP=3 is WAIT -> executes without stalling (pend consumed); a second WAIT at IP=4 stalls.
- Turbo held high -> Go high every cycle after 2-cycle sync delay, IP increments each cycle; Turbo dropped -> returns to CNT_MAX cadence without counter restart.
- Reset asserted while in WAIT at IP=8'h20 -> next cycle IP=0, Waiting=0, Go=0; a Sample press before Reset does not leave pend set.
